inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the RISC-V out-of-order core. It holds the program counter and a word-organised instruction memory, and fetches one instruction per unstalled cycle. Its registered instruction and stop outputs drive the IF/ID pipeline register directly. It also detects end of program and raises a sticky stop flag that travels down the pipeline with the instruction stream.

## Interface
- DEPTH, 256: instruction memory size in 32-bit words; power of two, at least 4.
- AW, 8: word-address width, equal to log2(DEPTH).
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous, active-low reset.
- load_en  input  1  memory write strobe; honoured only in IDLE.
- load_addr  input  AW  word address for load.
- load_data  input  32  instruction word to store.
- start  input  1  begin fetching from PC 0; honoured only in IDLE.
- stall_in  input  1  backpressure from downstream (RS/ROB full); freezes fetch.
- inst_IF_out  output  32  fetched instruction; feeds inst_IF_in of the IF/ID register.
- pc_IF_out  output  32  byte address of inst_IF_out.
- valid_out  output  1  inst_IF_out is a real instruction this cycle.
- stop_out  output  1  end of program reached; sticky until reset; feeds stop_in of the IF/ID register.

## Operation
- Memory is an internal array of DEPTH x 32 bits.
  - Written synchronously: mem[load_addr] <= load_data when load_en is high in IDLE.
  - Contents are not cleared by reset.
- Internal PC is 32 bits, byte addressed, always a multiple of 4. Word index is pc[AW+1:2].
- FSM states:
  - IDLE: wait for start. Loads are accepted. Outputs hold their reset values. start=1 loads pc to 0 and moves to FETCH next cycle.
  - FETCH: on each cycle with stall_in=0:
    - word = (pc>>2 < DEPTH) ? mem[pc>>2] : 0.
    - If word != 0: inst_IF_out <= word, pc_IF_out <= pc, valid_out <= 1, pc <= pc+4.
    - If word == 0 (end marker, or running past the last word): inst_IF_out <= 0, valid_out <= 0, stop_out <= 1, go to DONE. pc is not incremented.
  - FETCH with stall_in=1: pc, state and all outputs hold their values.
  - DONE: inst_IF_out=0, valid_out=0, stop_out=1, all held. start, load_en and stall_in are ignored. Only rstn leaves DONE.
- The PC comparison against DEPTH uses the full 32-bit pc. An index equal to DEPTH counts as out of range; there is no wrap-around to word 0.
- load_en in FETCH or DONE is ignored, so the memory is unchanged.
- start asserted while load_en is high in IDLE: the write completes, and fetch begins next cycle. The just-written word is visible to the first fetch.

## Timing
- All outputs are registered. Reset values: inst_IF_out=0, pc_IF_out=0, valid_out=0, stop_out=0, state=IDLE, pc=0.
- The async reset clears all outputs and state immediately, including in the middle of FETCH.
- Latency:
  - start sampled at edge N: state=FETCH after N.
  - The first instruction (pc 0) appears on the outputs after edge N+1.
- Throughput: one instruction per cycle while stall_in=0.
- stall_in is sampled at the clock edge. An instruction already presented stays on the outputs for every stalled cycle, and the next instruction appears one edge after stall_in falls.
- stop_out rises on the same edge that consumes the terminating zero word. Its first high cycle has valid_out=0.

## Test plan
- Reset and idle:
  - Hold rstn low, then release and run 5 cycles with start=0.
  - All outputs stay 0 and state stays IDLE.
- Straight-line program:
  - Load words 0..2 = 32'h00500093, 32'h00a00113, 32'h002081b3, and word 3 = 0. Pulse start.
  - Over consecutive cycles the outputs show (pc 0, 00500093), (pc 4, 00a00113), (pc 8, 002081b3), each with valid_out=1.
  - Next cycle: valid_out=0, stop_out=1, held for 10 or more cycles.
- Stall:
  - During the program above, raise stall_in for 3 cycles while pc_IF_out=4.
  - Outputs hold (4, 00a00113, valid=1) for those 3 cycles; pc 8 appears one edge after stall_in falls.
  - A stall raised on the cycle stop would assert delays stop_out by the same number of cycles.
- Full memory:
  - With DEPTH=4, load four nonzero words and start.
  - Four valid instructions appear at pc 0, 4, 8, 12, then stop_out=1 with no wrap to pc 0.
- Ignored inputs:
  - During FETCH, assert load_en at address 2 with 32'hdeadbeef.
  - The fetched word at pc 8 is the original value.
  - In DONE, start and stall_in have no effect.
- Reset mid-run:
  - Drop rstn while pc_IF_out=8. All outputs clear immediately.
  - After release and start, fetch restarts at pc 0 with the memory contents intact.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: program counter, word-organised instruction
// memory and the sticky end-of-program stop flag feeding the IF/ID register.
module inst_fetch #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          stall_in,
    output logic [31:0]   inst_IF_out,
    output logic [31:0]   pc_IF_out,
    output logic          valid_out,
    output logic          stop_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst_next;
    logic [31:0] pc_out_next;
    logic        valid_next;
    logic        stop_next;
    logic        mem_we;
    logic        in_range;
    logic [31:0] word;
    logic [31:0] mem [DEPTH];

    // A pc whose word index reaches DEPTH reads as the zero end marker, so
    // running off the end of memory stops the program instead of wrapping.
    assign in_range = (pc >> 2) < 32'(DEPTH);
    assign word     = in_range ? mem[pc[AW+1:2]] : 32'd0;

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // State, program counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pc          <= 32'd0;
            inst_IF_out <= 32'd0;
            pc_IF_out   <= 32'd0;
            valid_out   <= 1'b0;
            stop_out    <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            inst_IF_out <= inst_next;
            pc_IF_out   <= pc_out_next;
            valid_out   <= valid_next;
            stop_out    <= stop_next;
        end
    end

    // Next-state and next-output logic; everything holds unless a rule fires.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        inst_next   = inst_IF_out;
        pc_out_next = pc_IF_out;
        valid_next  = valid_out;
        stop_next   = stop_out;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                mem_we = load_en;
                if (start) begin
                    pc_next    = 32'd0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (!stall_in) begin
                    if (word != 32'd0) begin
                        inst_next   = word;
                        pc_out_next = pc;
                        valid_next  = 1'b1;
                        pc_next     = pc + 32'd4;
                    end else begin
                        inst_next  = 32'd0;
                        valid_next = 1'b0;
                        stop_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: a full-size and a four-word instance share the
// same stimulus and are both compared against a program-level reference model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = 8'd0;
    logic [31:0] load_data = 32'd0;
    logic        start = 1'b0;
    logic        stall_in = 1'b0;

    logic [31:0] inst_big, pc_big, inst_small, pc_small;
    logic        valid_big, stop_big, valid_small, stop_small;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: per instance, the memory image, whether the program is
    // idle/running/finished, and the index of the next word to issue.
    logic [31:0] m_mem [2][256];
    int          m_phase [2];
    int          m_nidx [2];
    logic [31:0] e_inst [2];
    logic [31:0] e_pc [2];
    logic        e_valid [2];
    logic        e_stop [2];

    inst_fetch #(.DEPTH(256), .AW(8)) dutBig (
        .clk(clk), .rstn(rstn), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall_in(stall_in),
        .inst_IF_out(inst_big), .pc_IF_out(pc_big),
        .valid_out(valid_big), .stop_out(stop_big)
    );

    inst_fetch #(.DEPTH(4), .AW(2)) dutSmall (
        .clk(clk), .rstn(rstn), .load_en(load_en), .load_addr(load_addr[1:0]),
        .load_data(load_data), .start(start), .stall_in(stall_in),
        .inst_IF_out(inst_small), .pc_IF_out(pc_small),
        .valid_out(valid_small), .stop_out(stop_small)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_nidx[k]  = 0;
            e_inst[k]  = 32'd0;
            e_pc[k]    = 32'd0;
            e_valid[k] = 1'b0;
            e_stop[k]  = 1'b0;
        end
    endtask

    // One clock edge of the program-level model: issue the next word of the
    // loaded program, or finish when the word is zero or memory runs out.
    task automatic modelStep();
        int depthK;
        if (!rstn) begin
            modelReset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            depthK = (k == 0) ? 256 : 4;
            if (m_phase[k] == 0) begin
                if (load_en) m_mem[k][int'(load_addr) % depthK] = load_data;
                if (start) begin
                    m_phase[k] = 1;
                    m_nidx[k]  = 0;
                end
            end else if (m_phase[k] == 1 && !stall_in) begin
                if (m_nidx[k] < depthK && m_mem[k][m_nidx[k]] != 32'd0) begin
                    e_inst[k]  = m_mem[k][m_nidx[k]];
                    e_pc[k]    = 32'(m_nidx[k] * 4);
                    e_valid[k] = 1'b1;
                    m_nidx[k]  = m_nidx[k] + 1;
                end else begin
                    e_inst[k]  = 32'd0;
                    e_valid[k] = 1'b0;
                    e_stop[k]  = 1'b1;
                    m_phase[k] = 2;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("big.inst", inst_big, e_inst[0]);
        checkOutput("big.pc", pc_big, e_pc[0]);
        checkOutput("big.valid", 32'(valid_big), 32'(e_valid[0]));
        checkOutput("big.stop", 32'(stop_big), 32'(e_stop[0]));
        checkOutput("small.inst", inst_small, e_inst[1]);
        checkOutput("small.pc", pc_small, e_pc[1]);
        checkOutput("small.valid", 32'(valid_small), 32'(e_valid[1]));
        checkOutput("small.stop", 32'(stop_small), 32'(e_stop[1]));
    endtask

    // Drive inputs mid-cycle, let one edge pass, then compare just after it.
    task automatic applyStimulus(input logic le, input logic [7:0] la,
                                 input logic [31:0] ld, input logic st,
                                 input logic sl);
        load_en   = le;
        load_addr = la;
        load_data = ld;
        start     = st;
        stall_in  = sl;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic resetPulse();
        rstn = 1'b0;
        idleCycle();
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] nonzeroWord();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'd0) w = 32'd1;
        return w;
    endfunction

    initial begin
        int          len;
        int          validCount;
        logic [31:0] w;

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) m_mem[k][i] = 32'd0;
        modelReset();

        // Reset held, then released with start low.
        repeat (3) idleCycle();
        rstn = 1'b1;
        repeat (5) idleCycle();

        // Straight-line program with a stall and an ignored load mid-fetch.
        applyStimulus(1'b1, 8'd0, 32'h00500093, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd1, 32'h00a00113, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd2, 32'h002081b3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd3, 32'h00000000, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("no_output_on_start_edge", 32'(valid_big), 32'd0);
        idleCycle();
        checkOutput("first_pc", pc_big, 32'd0);
        applyStimulus(1'b1, 8'd2, 32'hdeadbeef, 1'b0, 1'b0);
        checkOutput("pc_at_stall", pc_big, 32'd4);
        repeat (3) applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("held_through_stall", inst_big, 32'h00a00113);
        idleCycle();
        checkOutput("word_at_pc8", inst_big, 32'h002081b3);
        idleCycle();
        checkOutput("stop_raised", 32'(stop_big), 32'd1);
        repeat (12) applyStimulus($urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)),
                                  $urandom, $urandom_range(0, 1) == 1,
                                  $urandom_range(0, 1) == 1);

        // Asynchronous reset while pc 8 is being presented.
        resetPulse();
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
        repeat (3) idleCycle();
        checkOutput("pc_before_reset", pc_big, 32'd8);
        #2 rstn = 1'b0;
        #1 modelReset();
        checkAll();
        idleCycle();
        rstn = 1'b1;
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
        repeat (6) idleCycle();

        // Fill the four-word instance completely; it must stop without wrapping.
        resetPulse();
        applyStimulus(1'b1, 8'd4, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i), nonzeroWord(), 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
        validCount = 0;
        for (int i = 0; i < 8; i++) begin
            idleCycle();
            if (valid_small) validCount++;
        end
        checkOutput("small.valid_count", 32'(validCount), 32'd4);

        // Randomised programs with random stalls and ignored inputs.
        for (int iter = 0; iter < 25; iter++) begin
            resetPulse();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) applyStimulus(1'b1, 8'(i), nonzeroWord(), 1'b0, 1'b0);
            w = 32'($urandom_range(0, 1));
            applyStimulus(1'b1, 8'(len), 32'd0, w[0], 1'b0);
            if (w[0] == 1'b0) applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 1'b0);
            for (int c = 0; c < 3 * len + 10; c++)
                applyStimulus($urandom_range(0, 4) == 0, 8'($urandom_range(0, 15)),
                              $urandom, $urandom_range(0, 3) == 0,
                              $urandom_range(0, 9) < 3);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
